dm_bus: RTL and testbench
=========================

Name: dm_bus

Overview:
- Parametrised data memory for the CPU datapath, behind a valid/ready request port with a configurable wait-state count.
- Supports word, halfword and byte loads/stores, signed or unsigned load extension, and byte-lane merge on partial stores.
- Flags misaligned and out-of-range accesses as errors.
- Clears the whole array with a post-reset sweep FSM.
- Sits between the execute/memory stage and writeback; stage logic stalls on req_ready/rsp_valid.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2^ADDR_W words.
- LATENCY, 1, wait cycles between accept and response; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  DM_WORD 2'b00, DM_BYTE 2'b01, DM_HALF 2'b10; 2'b11 is illegal.
- req_uns  input  1  zero-extend loads; ignored for words and stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_pc  input  32  PC of the issuing instruction, for tracing only.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  error flag; valid only with rsp_valid.
- busy  output  1  clear sweep in progress.

Behaviour:
- Reset (reset=0, async):
  - state=CLEAR, sweep counter=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
  - Any in-flight request is dropped and never commits.
- CLEAR state:
  - Writes 0 to word[counter] each cycle and increments the counter.
  - After word 2^ADDR_W-1 is written, goes to IDLE; busy falls in the same cycle as the transition.
  - Sweep takes exactly 2^ADDR_W cycles.
- IDLE state:
  - req_ready=1.
  - On req_valid&&req_ready, captures all req_* fields.
  - Goes to WAIT with wait counter=LATENCY. If LATENCY=0, goes straight to RESP.
- WAIT state:
  - req_ready=0; decrement the counter each cycle; at 0, go to RESP.
- RESP state (one cycle):
  - rsp_valid=1; return to IDLE.
  - Store commit occurs on the clock edge that enters RESP.
  - A request accepted at edge T sees rsp_valid high in cycle T+1+LATENCY. The next accept is possible at T+2+LATENCY.
- Error checks, evaluated at accept:
  - Error cases: req_size=2'b11; HALF with addr[0]=1; WORD with addr[1:0]!=0; addr[31:ADDR_W+2]!=0.
  - On error: rsp_err=1, rsp_rdata=0, and memory is not written.
- Store lanes:
  - WORD writes all 4 bytes.
  - BYTE writes lane addr[1:0] with wdata[7:0].
  - HALF writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; upper half = {wdata[15:0], old[15:0]}.
  - Unselected bytes are preserved.
- Load extraction:
  - Selects the same lanes as stores.
  - Sign-extends from bit 7 or 15 unless req_uns=1.
  - Data is read in the RESP-entry cycle and registered into rsp_rdata.
- Outputs:
  - rsp_rdata and rsp_err are held at their last values outside RESP.
  - req_valid while req_ready=0 is ignored; the requester must hold it.
- A load to the same word immediately after a store returns the stored data, because the store commits before the next accept.

Optional Feature:
- Macro: DM_TRACE_EN.
- When defined, every committed store prints "@%h: *%h <= %h" with captured PC, byte address, and the merged full word, at the commit edge.
- When undefined, no $display and no simulation-only logic.
- Functional behaviour is identical either way.

Decomposition:
- Package dm_pkg holds:
  - DM_WORD/DM_HALF/DM_BYTE size constants.
  - FSM state enum CLEAR/IDLE/WAIT/RESP.
  - Lane-mask function (size, addr[1:0] -> 4-bit byte enable).
  - Load-extend function.
- One sub-module, dm_lane_merge (combinational): old word, wdata, byte enable -> merged word.
- FSM, counters and the array stay in dm_bus.

Test Plan:
- Reset then sweep, ADDR_W=4: release reset -> busy high exactly 16 cycles, then req_ready=1; load WORD 0x3C -> rdata 0x00000000, err=0.
- Lane stores, LATENCY=2: SW 0x8 <= 0x11223344, SB 0x9 <= 0xAB, SH 0xA <= 0xBEEF; then LW 0x8 -> 0xBEEFAB44; each rsp_valid arrives 3 cycles after accept.
- Extension: memory word 0x8 = 0x80FF7F01; LB 0x9 -> 0xFFFFFF7F? No: byte 1 = 0x7F -> 0x0000007F. LB 0xA -> 0xFFFFFFFF; LBU 0xA -> 0x000000FF; LH 0xA -> 0xFFFF80FF; LHU 0xA -> 0x000080FF.
- Errors: SH 0x5, SW 0x6, req_size 2'b11, LW 0x1000 with ADDR_W=10 -> rsp_err=1, rdata 0; following LW shows memory unchanged.
- Reset mid-operation: SW accepted, reset asserted during WAIT -> outputs zero immediately; after the sweep, the target word reads 0.
- Back-to-back, LATENCY=0: req_valid held high for 4 requests -> accepts every 2nd cycle, rsp_valid pulses every 2nd cycle; DM_TRACE_EN build prints 4 lines for 4 stores.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared size codes, FSM states and lane helpers for the dm_bus data memory.
package dm_pkg;

   localparam logic [1:0] DM_WORD = 2'b00;
   localparam logic [1:0] DM_BYTE = 2'b01;
   localparam logic [1:0] DM_HALF = 2'b10;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      WAIT,
      RESP
   } dm_state_t;

   // Byte enables for an access; the illegal size code selects no lanes.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         DM_WORD: be = 4'b1111;
         DM_BYTE: be = 4'b0001 << addr_lo;
         DM_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Pulls the addressed lanes down to bit 0 and sign- or zero-extends them.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] addr_lo, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] result;
      b = word[{addr_lo, 3'b000} +: 8];
      h = addr_lo[1] ? word[31:16] : word[15:0];
      case (size)
         DM_BYTE: result = {{24{~uns & b[7]}}, b};
         DM_HALF: result = {{16{~uns & h[15]}}, h};
         default: result = word;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dm_bus_if.sv
// Request/response bundle between the memory stage (master) and dm_bus (slave).
interface dm_bus_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_uns, req_addr, req_wdata, req_pc,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata, req_pc,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dm_lane_merge.sv
// Combinational byte-lane merge: enabled lanes come from lane-aligned store data, the rest keep the old word.
module dm_lane_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
   end

endmodule

// File: rtl/dm_bus.sv
// Data memory behind a valid/ready port with LATENCY wait states and a post-reset clear sweep.
// Define DM_TRACE_EN to print every committed store.
module dm_bus
   import dm_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input  logic     clk,
   input  logic     reset,
   dm_bus_if.slave  bus,
   output logic     busy
);

   localparam int         DEPTH = 1 << ADDR_W;
   localparam logic [3:0] LAT   = 4'(LATENCY);

   dm_state_t         state;
   dm_state_t         state_next;
   logic [ADDR_W-1:0] sweep_cnt;
   logic [3:0]        wait_cnt;

   logic              cap_we;
   logic              cap_uns;
   logic [1:0]        cap_size;
   logic [31:0]       cap_addr;
   logic [31:0]       cap_wdata;
   logic [31:0]       cap_pc;

   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;
   logic [31:0]       mem [DEPTH];

   logic              use_live;
   logic              accept;
   logic              enter_resp;
   logic              commit;
   logic              op_we;
   logic              op_uns;
   logic              op_err;
   logic [1:0]        op_size;
   logic [31:0]       op_addr;
   logic [31:0]       op_wdata;
   logic [31:0]       op_pc;
   logic [ADDR_W-1:0] op_idx;
   logic [31:0]       old_word;
   logic [31:0]       lane_data;
   logic [31:0]       merged;
   logic [3:0]        be;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;

   // With zero wait states the response is set up in the accept cycle, so the live request feeds the datapath in IDLE.
   assign use_live = (state == IDLE);
   assign op_we    = use_live ? bus.req_we    : cap_we;
   assign op_uns   = use_live ? bus.req_uns   : cap_uns;
   assign op_size  = use_live ? bus.req_size  : cap_size;
   assign op_addr  = use_live ? bus.req_addr  : cap_addr;
   assign op_wdata = use_live ? bus.req_wdata : cap_wdata;
   assign op_pc    = use_live ? bus.req_pc    : cap_pc;

   assign accept   = (state == IDLE) && bus.req_valid;
   assign op_idx   = op_addr[ADDR_W+1:2];
   assign old_word = mem[op_idx];
   assign be       = lane_mask(op_size, op_addr[1:0]);
   assign op_err   = (op_size == 2'b11)
                  || ((op_size == DM_HALF) && op_addr[0])
                  || ((op_size == DM_WORD) && (op_addr[1:0] != 2'b00))
                  || (op_addr[31:ADDR_W+2] != '0);
   assign commit   = enter_resp && op_we && !op_err;

   always_comb begin
      case (op_size)
         DM_BYTE: lane_data = {4{op_wdata[7:0]}};
         DM_HALF: lane_data = {2{op_wdata[15:0]}};
         default: lane_data = op_wdata;
      endcase
   end

   dm_lane_merge u_merge (
      .old_word (old_word),
      .wdata    (lane_data),
      .be       (be),
      .merged   (merged)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= CLEAR;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      enter_resp = 1'b0;
      case (state)
         CLEAR: if (&sweep_cnt) state_next = IDLE;
         IDLE: begin
            if (bus.req_valid) begin
               if (LAT == 4'd0) begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd1) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = CLEAR;
      endcase
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = (state == CLEAR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sweep_cnt   <= '0;
         wait_cnt    <= '0;
         cap_we      <= 1'b0;
         cap_uns     <= 1'b0;
         cap_size    <= DM_WORD;
         cap_addr    <= '0;
         cap_wdata   <= '0;
         cap_pc      <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (state == CLEAR) sweep_cnt <= sweep_cnt + 1'b1;
         if (accept) begin
            cap_we    <= bus.req_we;
            cap_uns   <= bus.req_uns;
            cap_size  <= bus.req_size;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_pc    <= bus.req_pc;
            wait_cnt  <= LAT;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (enter_resp) begin
            rsp_err_q   <= op_err;
            rsp_rdata_q <= (op_we || op_err) ? '0 : load_extend(old_word, op_size, op_addr[1:0], op_uns);
         end
      end
   end

   // Single write port shared by the clear sweep and store commits; the array itself is never reset.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = op_idx;
      mem_wdata = merged;
      if (state == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = sweep_cnt;
         mem_wdata = '0;
      end else if (commit) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

`ifdef DM_TRACE_EN
   always_ff @(posedge clk) begin
      if (commit) $display("@%h: *%h <= %h", op_pc, op_addr, merged);
   end
`else
   logic unused_pc;
   assign unused_pc = ^op_pc;
`endif

endmodule

// File: tb/tb_dm_bus.sv
// Scoreboard bench for dm_bus: a LATENCY=2 and a LATENCY=0 instance checked against a byte-array memory model.
module tb_dm_bus;
   import dm_pkg::*;

   localparam int AW     = 4;
   localparam int NBYTES = 4 << AW;
   localparam int LAT0   = 2;
   localparam int LAT1   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        t_valid [2];
   logic        t_we    [2];
   logic        t_uns   [2];
   logic [1:0]  t_size  [2];
   logic [31:0] t_addr  [2];
   logic [31:0] t_wdata [2];
   logic [31:0] t_pc    [2];
   wire         o_ready  [2];
   wire         o_rvalid [2];
   wire         o_err    [2];
   wire         o_busy   [2];
   wire  [31:0] o_rdata  [2];

   exp_t        expq [2][$];
   logic [7:0]  mb [2][NBYTES];
   int          last_acc [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      dm_bus_if bus ();
      assign bus.req_valid = t_valid[g];
      assign bus.req_we    = t_we[g];
      assign bus.req_size  = t_size[g];
      assign bus.req_uns   = t_uns[g];
      assign bus.req_addr  = t_addr[g];
      assign bus.req_wdata = t_wdata[g];
      assign bus.req_pc    = t_pc[g];
      assign o_ready[g]    = bus.req_ready;
      assign o_rvalid[g]   = bus.rsp_valid;
      assign o_rdata[g]    = bus.rsp_rdata;
      assign o_err[g]      = bus.rsp_err;

      dm_bus #(.ADDR_W(AW), .LATENCY(g == 0 ? LAT0 : LAT1)) dut (
         .clk   (clk),
         .reset (rst_n),
         .bus   (bus),
         .busy  (o_busy[g])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   function automatic int size_bytes(input logic [1:0] size);
      case (size)
         DM_WORD: return 4;
         DM_HALF: return 2;
         DM_BYTE: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Issues one request, updates the model and queues the expected response at the accept point.
   task automatic applyStimulus(input int d, input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit hold, input bit b2b);
      exp_t        e;
      int          n;
      logic [31:0] v;
      bit          got;
      n       = size_bytes(size);
      e.err   = 1'b0;
      e.rdata = '0;
      if (n == 0 || addr >= 32'(NBYTES)) e.err = 1'b1;
      else if (addr % n != 0)            e.err = 1'b1;
      if (!e.err && we) begin
         for (int k = 0; k < n; k++) mb[d][addr + k] = wdata[8*k +: 8];
      end else if (!e.err) begin
         v = '0;
         for (int k = 0; k < n; k++) v = v | (32'(mb[d][addr + k]) << (8*k));
         if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         e.rdata = v;
      end
      t_we[d]    = we;
      t_size[d]  = size;
      t_uns[d]   = uns;
      t_addr[d]  = addr;
      t_wdata[d] = wdata;
      t_pc[d]    = $urandom;
      t_valid[d] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (o_ready[d] === 1'b1) begin
            got = 1'b1;
            if (b2b) checkOutput($sformatf("b2b_spacing_dut%0d", d), 32'(cyc - last_acc[d]), 32'(lat_of(d) + 2));
            last_acc[d] = cyc;
            e.due = cyc + 1 + lat_of(d);
            expq[d].push_back(e);
         end
         @(negedge clk);
      end
      if (!got) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout_dut%0d: req_ready not seen, required within 60 cycles", d);
      end
      if (!hold) t_valid[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (expq[d].size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput($sformatf("drain_dut%0d", d), 32'(expq[d].size()), 32'd0);
   endtask

   task automatic doReset();
      int n;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         expq[d].delete();
         t_valid[d] = 1'b0;
         for (int b = 0; b < NBYTES; b++) mb[d][b] = 8'h00;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("rst_ready_dut%0d", d), 32'(o_ready[d]), 32'd0);
         checkOutput($sformatf("rst_rvalid_dut%0d", d), 32'(o_rvalid[d]), 32'd0);
         checkOutput($sformatf("rst_rdata_dut%0d", d), o_rdata[d], 32'd0);
         checkOutput($sformatf("rst_err_dut%0d", d), 32'(o_err[d]), 32'd0);
         checkOutput($sformatf("rst_busy_dut%0d", d), 32'(o_busy[d]), 32'd1);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (o_busy[0] === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("sweep_cycles", 32'(n), 32'(1 << AW));
      checkOutput("ready_after_sweep", 32'(o_ready[0]), 32'd1);
      checkOutput("busy_dut1_after_sweep", 32'(o_busy[1]), 32'd0);
   endtask

   // Monitor: every response pulse pops one expectation and checks data, error and arrival cycle.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rst_n && o_rvalid[d] === 1'b1) begin
            if (expq[d].size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_rsp_dut%0d: rsp_valid=1, required no response", d);
            end else begin
               e = expq[d].pop_front();
               checkOutput($sformatf("rdata_dut%0d", d), o_rdata[d], e.rdata);
               checkOutput($sformatf("err_dut%0d", d), 32'(o_err[d]), 32'(e.err));
               checkOutput($sformatf("rsp_cycle_dut%0d", d), 32'(cyc), 32'(e.due));
            end
         end
      end
   end

   initial begin
      logic [31:0] addr;
      logic [1:0]  size;
      int          r;
      bit          hold;
      bit          prev_hold;
      for (int d = 0; d < 2; d++) begin
         t_valid[d] = 1'b0; t_we[d] = 1'b0; t_uns[d] = 1'b0; t_size[d] = DM_WORD;
         t_addr[d] = '0; t_wdata[d] = '0; t_pc[d] = '0; last_acc[d] = 0;
      end
      @(negedge clk);
      doReset();

      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h3C, 32'h0, 0, 0);
      applyStimulus(1, 1'b0, DM_WORD, 1'b0, 32'h3C, 32'h0, 0, 0);

      applyStimulus(0, 1'b1, DM_WORD, 1'b0, 32'h8, 32'h11223344, 0, 0);
      applyStimulus(0, 1'b1, DM_BYTE, 1'b0, 32'h9, 32'h000000AB, 0, 0);
      applyStimulus(0, 1'b1, DM_HALF, 1'b0, 32'hA, 32'h0000BEEF, 0, 0);
      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h8, 32'h0, 0, 0);

      applyStimulus(0, 1'b1, DM_WORD, 1'b0, 32'h8, 32'h80FF7F01, 0, 0);
      applyStimulus(0, 1'b0, DM_BYTE, 1'b0, 32'h9, 32'h0, 0, 0);
      applyStimulus(0, 1'b0, DM_BYTE, 1'b0, 32'hA, 32'h0, 0, 0);
      applyStimulus(0, 1'b0, DM_BYTE, 1'b1, 32'hA, 32'h0, 0, 0);
      applyStimulus(0, 1'b0, DM_HALF, 1'b0, 32'hA, 32'h0, 0, 0);
      applyStimulus(0, 1'b0, DM_HALF, 1'b1, 32'hA, 32'h0, 0, 0);

      applyStimulus(0, 1'b1, DM_HALF, 1'b0, 32'h5, 32'hFFFFFFFF, 0, 0);
      applyStimulus(0, 1'b1, DM_WORD, 1'b0, 32'h6, 32'hFFFFFFFF, 0, 0);
      applyStimulus(0, 1'b1, 2'b11,   1'b0, 32'h8, 32'hFFFFFFFF, 0, 0);
      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h1000, 32'h0, 0, 0);
      applyStimulus(0, 1'b1, DM_WORD, 1'b0, 32'h40, 32'hFFFFFFFF, 0, 0);
      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h4, 32'h0, 0, 0);
      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h8, 32'h0, 0, 0);
      applyStimulus(0, 1'b1, DM_WORD, 1'b0, 32'h3C, 32'hCAFEF00D, 0, 0);
      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h3C, 32'h0, 0, 0);

      for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, DM_WORD, 1'b0, 32'(4*i), $urandom, i < 3, i > 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, DM_WORD, 1'b0, 32'(4*i), 32'h0, i < 3, i > 0);

      for (int d = 0; d < 2; d++) begin
         prev_hold = 1'b0;
         for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'(NBYTES) + $urandom_range(0, 7);
            else             addr = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            size = (r == 9) ? 2'b11 : 2'(r % 3);
            hold = ($urandom_range(0, 3) == 0) && (i < 149);
            applyStimulus(d, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
                          hold, prev_hold);
            prev_hold = hold;
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         drain(d);
      end

      applyStimulus(0, 1'b1, DM_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 0, 0);
      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h10, 32'h0, 0, 0);
      drain(0);
      applyStimulus(0, 1'b1, DM_WORD, 1'b0, 32'h14, 32'h12345678, 0, 0);
      doReset();
      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h14, 32'h0, 0, 0);
      applyStimulus(0, 1'b0, DM_WORD, 1'b0, 32'h10, 32'h0, 0, 0);

      repeat (5) @(negedge clk);
      drain(0);
      drain(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
